// File: rtl/scrambler_64b66b_if.sv
// Word stream between the 64b/66b encoder, the scrambler and the gearbox.
// Signal names keep the scrambler's own port naming so they read the same on both sides.
interface scrambler_64b66b_if #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2
);
    logic                  i_encoded_data_valid;
    logic [DATA_WIDTH-1:0] i_encoded_data;
    logic [HDR_WIDTH-1:0]  i_sync_hdr;
    logic                  i_encoding_err;
    logic                  o_scrambler_trdy;
    logic                  i_gearbox_trdy;
    logic                  o_scrambled_valid;
    logic [DATA_WIDTH-1:0] o_scrambled_data;
    logic [HDR_WIDTH-1:0]  o_sync_hdr;
    logic                  o_hdr_valid;
    logic                  o_block_err;
    logic [15:0]           o_err_cnt;

    // Scrambler side.
    modport slave (
        input  i_encoded_data_valid, i_encoded_data, i_sync_hdr, i_encoding_err, i_gearbox_trdy,
        output o_scrambler_trdy, o_scrambled_valid, o_scrambled_data, o_sync_hdr,
        output o_hdr_valid, o_block_err, o_err_cnt
    );

    // Encoder/gearbox side.
    modport master (
        output i_encoded_data_valid, i_encoded_data, i_sync_hdr, i_encoding_err, i_gearbox_trdy,
        input  o_scrambler_trdy, o_scrambled_valid, o_scrambled_data, o_sync_hdr,
        input  o_hdr_valid, o_block_err, o_err_cnt
    );
endinterface

// File: rtl/scrambler_64b66b.sv
// Self-synchronous 64b/66b payload scrambler (G(x)=1+x^39+x^58), half a block per word,
// with block-level error tagging and a skid buffer behind a one-word output register.
module scrambler_64b66b #(
    parameter int DATA_WIDTH       = 32,
    parameter int HDR_WIDTH        = 2,
    parameter int SCRAMBLER_BYPASS = 0
) (
    input logic           i_clk,
    input logic           i_reset_n,
    scrambler_64b66b_if.slave bus
);

    // Handshake: a word moves on a rising edge where valid and ready are both 1; valid never
    // waits on ready, and a presented word plus its header/flags hold still until it moves.

    localparam int         DEPTH      = 3;
    localparam logic [57:0] STATE_INIT = {58{1'b1}};

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [HDR_WIDTH-1:0]  hdr;
        logic                  first;
        logic                  err;
    } word_t;

    word_t                 q   [DEPTH];
    word_t                 q_n [DEPTH];
    word_t                 new_word;
    logic [1:0]            cnt, cnt_n;
    logic [57:0]           state, state_n;
    logic                  phase;
    logic [HDR_WIDTH-1:0]  hdr_lat;
    logic                  err_lat;
    logic                  trdy;
    logic [15:0]           err_cnt, err_cnt_n;
    logic                  accept, out_valid, pop, blk_err;
    logic [57+DATA_WIDTH:0] ext;
    logic [DATA_WIDTH-1:0] scr_word;

    assign accept    = bus.i_encoded_data_valid & trdy;
    // A lone phase-0 word at the head stays hidden until its block error is known.
    assign out_valid = (cnt != 2'd0) && !((cnt == 2'd1) && phase);
    assign pop       = out_valid & bus.i_gearbox_trdy;
    assign blk_err   = phase & (err_lat | bus.i_encoding_err);

    // ext[57:0] is history (ext[57] newest); ext[58+i] is the scrambled bit for data bit i.
    always_comb begin
        ext = '0;
        ext[57:0] = state;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ext[58+i] = bus.i_encoded_data[i] ^ ext[i+19] ^ ext[i];
        end
        state_n  = ext[57+DATA_WIDTH -: 58];
        scr_word = (SCRAMBLER_BYPASS != 0) ? bus.i_encoded_data : ext[57+DATA_WIDTH:58];
    end

    always_comb begin
        new_word       = '0;
        new_word.data  = scr_word;
        new_word.hdr   = phase ? hdr_lat : bus.i_sync_hdr;
        new_word.first = ~phase;
        new_word.err   = phase ? blk_err : bus.i_encoding_err;
    end

    always_comb begin
        q_n   = q;
        cnt_n = cnt;
        // The phase-0 partner is always the youngest entry when a phase-1 word arrives.
        for (int k = 0; k < DEPTH; k++) begin
            if (accept && phase && (k + 1 == int'(cnt))) begin
                q_n[k].err = blk_err;
            end
        end
        if (pop) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                q_n[k] = q_n[k+1];
            end
            cnt_n = cnt_n - 2'd1;
        end
        if (accept) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k == int'(cnt_n)) begin
                    q_n[k] = new_word;
                end
            end
            cnt_n = cnt_n + 2'd1;
        end
    end

    always_comb begin
        err_cnt_n = err_cnt;
        if (accept && blk_err && (err_cnt != 16'hFFFF)) begin
            err_cnt_n = err_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                q[k] <= '0;
            end
            cnt     <= 2'd0;
            state   <= STATE_INIT;
            phase   <= 1'b0;
            hdr_lat <= '0;
            err_lat <= 1'b0;
            trdy    <= 1'b0;
            err_cnt <= 16'd0;
        end else begin
            q       <= q_n;
            cnt     <= cnt_n;
            trdy    <= (cnt_n != 2'd3);
            err_cnt <= err_cnt_n;
            if (accept) begin
                state <= state_n;
                phase <= ~phase;
                if (!phase) begin
                    hdr_lat <= bus.i_sync_hdr;
                    err_lat <= bus.i_encoding_err;
                end
            end
        end
    end

    assign bus.o_scrambler_trdy  = trdy;
    assign bus.o_scrambled_valid = out_valid;
    assign bus.o_scrambled_data  = q[0].data;
    assign bus.o_sync_hdr        = q[0].hdr;
    assign bus.o_hdr_valid       = out_valid & q[0].first;
    assign bus.o_block_err       = out_valid & q[0].err;
    assign bus.o_err_cnt         = err_cnt;

endmodule

// File: tb/tb_scrambler_64b66b.sv
// Directed bench for scrambler_64b66b: a scrambling DUT and a bypass DUT share one stimulus
// stream; a bit-serial model, expected queues and a descrambler model judge the outputs.
module tb_scrambler_64b66b;
    localparam int DW = 32;
    localparam int HW = 2;
    localparam int EW = DW + HW + 2;

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b1;
    always #5 i_clk = ~i_clk;

    scrambler_64b66b_if #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) bus ();
    scrambler_64b66b_if #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) byp_bus ();

    scrambler_64b66b #(.DATA_WIDTH(DW), .HDR_WIDTH(HW), .SCRAMBLER_BYPASS(0)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus));
    scrambler_64b66b #(.DATA_WIDTH(DW), .HDR_WIDTH(HW), .SCRAMBLER_BYPASS(1)) dut_byp (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(byp_bus));

    assign byp_bus.i_encoded_data_valid = bus.i_encoded_data_valid;
    assign byp_bus.i_encoded_data       = bus.i_encoded_data;
    assign byp_bus.i_sync_hdr           = bus.i_sync_hdr;
    assign byp_bus.i_encoding_err       = bus.i_encoding_err;
    assign byp_bus.i_gearbox_trdy       = bus.i_gearbox_trdy;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [EW-1:0]   exp_q[$];
    logic [EW-1:0]   byp_q[$];
    logic [DW-1:0]   orig_q[$];
    logic [DW-1:0]   obs_q[$];
    logic [DW-1:0]   byp_obs_q[$];
    logic [57:0]     m_sr;
    logic            m_phase;
    logic [DW-1:0]   m_s0, m_d0;
    logic [HW-1:0]   m_hdr;
    logic            m_err0;
    logic [15:0]     m_errcnt;
    logic [57:0]     desc_r;
    int              desc_n;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: m_sr[0] is the newest scrambled bit.
    task automatic model_scramble(input logic [DW-1:0] d, output logic [DW-1:0] s);
        logic b;
        for (int i = 0; i < DW; i++) begin
            b    = d[i] ^ m_sr[38] ^ m_sr[57];
            s[i] = b;
            m_sr = {m_sr[56:0], b};
        end
    endtask

    task automatic model_reset();
        m_sr     = {58{1'b1}};
        m_phase  = 1'b0;
        m_err0   = 1'b0;
        m_errcnt = 16'd0;
        exp_q.delete();
        byp_q.delete();
        orig_q.delete();
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic [HW-1:0] h, input logic e);
        logic [DW-1:0] s;
        logic          be;
        model_scramble(d, s);
        if (!m_phase) begin
            m_s0 = s; m_d0 = d; m_hdr = h; m_err0 = e; m_phase = 1'b1;
        end else begin
            be = m_err0 | e;
            exp_q.push_back({m_s0, m_hdr, 1'b1, be});
            exp_q.push_back({s, m_hdr, 1'b0, be});
            byp_q.push_back({m_d0, m_hdr, 1'b1, be});
            byp_q.push_back({d, m_hdr, 1'b0, be});
            orig_q.push_back(m_d0);
            orig_q.push_back(d);
            if (be && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
            m_phase = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the word was accepted.
    task automatic send_word(input logic [DW-1:0] d, input logic [HW-1:0] h, input logic e);
        int waited = 0;
        bus.i_encoded_data_valid = 1'b1;
        bus.i_encoded_data       = d;
        bus.i_sync_hdr           = h;
        bus.i_encoding_err       = e;
        @(negedge i_clk);
        while (!bus.o_scrambler_trdy && waited < 200) begin
            @(negedge i_clk);
            waited++;
        end
        if (!bus.o_scrambler_trdy) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            bus.i_encoded_data_valid = 1'b0;
        end else begin
            @(posedge i_clk);
            #1;
            bus.i_encoded_data_valid = 1'b0;
            model_accept(d, h, e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || byp_q.size() != 0) && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check_eq("drain_empty", 64'(exp_q.size() + byp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_valid",   64'(bus.o_scrambled_valid), 64'd0);
        check_eq("rst_trdy",    64'(bus.o_scrambler_trdy),  64'd0);
        check_eq("rst_hdr_vld", 64'(bus.o_hdr_valid),       64'd0);
        check_eq("rst_blk_err", 64'(bus.o_block_err),       64'd0);
        check_eq("rst_data",    64'(bus.o_scrambled_data),  64'd0);
        check_eq("rst_hdr",     64'(bus.o_sync_hdr),        64'd0);
        check_eq("rst_err_cnt", 64'(bus.o_err_cnt),         64'd0);
    endtask

    task automatic monitor();
        logic [EW-1:0] e;
        logic [DW-1:0] rec, o;
        logic          b;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                desc_r = 58'({$urandom(), $urandom()});
                desc_n = 0;
            end else begin
                if (bus.o_scrambled_valid && bus.i_gearbox_trdy) begin
                    if (exp_q.size() == 0) check_eq("main_extra", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        check_eq("main_word", 64'({bus.o_scrambled_data, bus.o_sync_hdr,
                                 bus.o_hdr_valid, bus.o_block_err}), 64'(e));
                    end
                    obs_q.push_back(bus.o_scrambled_data);
                    for (int i = 0; i < DW; i++) begin
                        b      = bus.o_scrambled_data[i];
                        rec[i] = b ^ desc_r[38] ^ desc_r[57];
                        desc_r = {desc_r[56:0], b};
                    end
                    if (orig_q.size() != 0) begin
                        o = orig_q.pop_front();
                        if (desc_n >= 2) check_eq("descramble", 64'(rec), 64'(o));
                    end
                    desc_n++;
                end
                if (byp_bus.o_scrambled_valid && byp_bus.i_gearbox_trdy) begin
                    if (byp_q.size() == 0) check_eq("byp_extra", 64'd1, 64'd0);
                    else begin
                        e = byp_q.pop_front();
                        check_eq("byp_word", 64'({byp_bus.o_scrambled_data, byp_bus.o_sync_hdr,
                                 byp_bus.o_hdr_valid, byp_bus.o_block_err}), 64'(e));
                    end
                    byp_obs_q.push_back(byp_bus.o_scrambled_data);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EW-1:0] hd;
        bus.i_encoded_data_valid = 1'b0;
        bus.i_encoded_data       = '0;
        bus.i_sync_hdr           = '0;
        bus.i_encoding_err       = 1'b0;
        bus.i_gearbox_trdy       = 1'b1;
        model_reset();
        fork monitor(); join_none

        // Reset values and registered ready after release
        #2 i_reset_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        #1 check_eq("trdy_before_edge", 64'(bus.o_scrambler_trdy), 64'd0);
        @(negedge i_clk);
        check_eq("trdy_after_release", 64'(bus.o_scrambler_trdy), 64'd1);
        @(posedge i_clk);
        #1;

        // Reset-state vector: two zero words from the all-ones state
        obs_q.delete();
        send_word(32'h0000_0000, 2'b01, 1'b0);
        send_word(32'h0000_0000, 2'b01, 1'b0);
        drain();
        check_eq("v0_count", 64'(obs_q.size()), 64'd2);
        check_eq("v0_word0", 64'(obs_q[0]), 64'h0000_0000);
        check_eq("v0_word1", 64'(obs_q[1]), 64'h03FF_FF80);

        // Bypass keeps data and order; header on phase 1 is ignored
        byp_obs_q.delete();
        send_word(32'hDEAD_BEEF, 2'b10, 1'b0);
        send_word(32'h0123_4567, 2'b11, 1'b0);
        drain();
        check_eq("byp_count", 64'(byp_obs_q.size()), 64'd2);
        check_eq("byp_word0", 64'(byp_obs_q[0]), 64'hDEAD_BEEF);
        check_eq("byp_word1", 64'(byp_obs_q[1]), 64'h0123_4567);

        // Error on phase 1, then on phase 0, then a clean block
        send_word(32'h1111_2222, 2'b01, 1'b0);
        send_word(32'h3333_4444, 2'b01, 1'b1);
        check_eq("errcnt_p1", 64'(bus.o_err_cnt), 64'(m_errcnt));
        send_word(32'h5555_6666, 2'b10, 1'b1);
        send_word(32'h7777_8888, 2'b10, 1'b0);
        check_eq("errcnt_p0", 64'(bus.o_err_cnt), 64'(m_errcnt));
        send_word(32'h9999_AAAA, 2'b01, 1'b0);
        send_word(32'hBBBB_CCCC, 2'b01, 1'b0);
        check_eq("errcnt_clean", 64'(bus.o_err_cnt), 64'd2);
        drain();

        // Backpressure: output stalled, two more words fill the skid buffer
        bus.i_gearbox_trdy = 1'b0;
        for (int w = 0; w < 3; w++) send_word(32'($urandom()), 2'b01, 1'b0);
        @(negedge i_clk);
        check_eq("bp_trdy_low", 64'(bus.o_scrambler_trdy), 64'd0);
        for (int c = 0; c < 5; c++) begin
            hd = exp_q[0];
            check_eq("bp_valid", 64'(bus.o_scrambled_valid), 64'd1);
            check_eq("bp_hold_data", 64'(bus.o_scrambled_data), 64'(hd[EW-1 -: DW]));
            @(negedge i_clk);
        end
        @(posedge i_clk);
        #1 bus.i_gearbox_trdy = 1'b1;
        for (int w = 0; w < 13; w++) send_word(32'($urandom()), 2'b10, 1'b0);
        drain();

        // Random stream under random downstream stalls
        fork
            begin
                for (int w = 0; w < 40; w++) begin
                    send_word(32'($urandom()), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
                              ($urandom_range(0, 7) == 0));
                end
            end
            begin
                repeat (80) begin
                    @(posedge i_clk);
                    #1 bus.i_gearbox_trdy = ($urandom_range(0, 3) != 0);
                end
                bus.i_gearbox_trdy = 1'b1;
            end
        join
        drain();
        check_eq("errcnt_stream", 64'(bus.o_err_cnt), 64'(m_errcnt));

        // Saturation from one below the top
        force dut.err_cnt = 16'hFFFE;
        @(posedge i_clk);
        #1 release dut.err_cnt;
        m_errcnt = 16'hFFFE;
        send_word(32'hA5A5_0001, 2'b01, 1'b0);
        send_word(32'hA5A5_0002, 2'b01, 1'b1);
        check_eq("sat_reach", 64'(bus.o_err_cnt), 64'hFFFF);
        send_word(32'hA5A5_0003, 2'b01, 1'b1);
        send_word(32'hA5A5_0004, 2'b01, 1'b1);
        check_eq("sat_hold", 64'(bus.o_err_cnt), 64'hFFFF);
        drain();

        // Reset after a phase-0 word: everything clears, block is dropped
        send_word(32'hCAFE_F00D, 2'b01, 1'b0);
        i_reset_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check_eq("trdy_after_reset", 64'(bus.o_scrambler_trdy), 64'd1);
        @(posedge i_clk);
        #1;
        obs_q.delete();
        send_word(32'h0000_0000, 2'b10, 1'b0);
        send_word(32'h0000_0000, 2'b01, 1'b0);
        drain();
        check_eq("post_rst_count", 64'(obs_q.size()), 64'd2);
        check_eq("post_rst_word0", 64'(obs_q[0]), 64'h0000_0000);
        check_eq("post_rst_word1", 64'(obs_q[1]), 64'h03FF_FF80);

        repeat (5) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
